// File: rtl/shift_cmd_sequencer.sv
// Command FIFO + result register front-end for an external 4-bit barrel shifter.
// Optional `SHIFT_SEQ_OPCOUNT_EN adds a 16-bit count of completed output handshakes.
module shift_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [1:0]               in_shift,
    input  logic [1:0]               in_mode,
    output logic [DATA_W-1:0]        sh_data_in,
    output logic [1:0]               sh_shift,
    output logic [1:0]               sh_mode,
    input  logic [DATA_W-1:0]        sh_data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [1:0]               out_mode,
    output logic [$clog2(DEPTH):0]   level
`ifdef SHIFT_SEQ_OPCOUNT_EN
    ,
    output logic [15:0]              op_count
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        shift;
        logic [1:0]        mode;
    } cmd_t;

    typedef enum logic {IDLE, HOLD} state_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    state_t        state;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign level    = wr_ptr - rd_ptr;
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = !empty && ((state == IDLE) || out_ready);

    assign head       = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign sh_data_in = head.data;
    assign sh_shift   = head.shift;
    assign sh_mode    = head.mode;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= '{data: in_data, shift: in_shift, mode: in_mode};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Result register: a pop always lands a new result; otherwise a drained
    // result just drops valid and leaves data/mode untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mode  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_data  <= sh_data_out;
                        out_mode  <= head.mode;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (!empty) begin
                            out_data <= sh_data_out;
                            out_mode <= head.mode;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHIFT_SEQ_OPCOUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count <= '0;
        else if (out_valid && out_ready)
            op_count <= op_count + 16'd1;
    end
`endif

endmodule
